// File: rtl/rl_ram_1r1w_fwd_if.sv
// Request/response bundle for the 1R1W RAM.
// master drives write/read requests, slave returns read data.
interface rl_ram_1r1w_fwd_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 32
);
    localparam int NBE = (DBITS + 7) / 8;

    logic [ABITS-1:0] waddr_i;
    logic [DBITS-1:0] din_i;
    logic             we_i;
    logic [NBE-1:0]   be_i;
    logic [ABITS-1:0] raddr_i;
    logic             re_i;
    logic [DBITS-1:0] dout_o;
    logic             dout_valid_o;

    modport master (
        output waddr_i, din_i, we_i, be_i, raddr_i, re_i,
        input  dout_o, dout_valid_o
    );

    modport slave (
        input  waddr_i, din_i, we_i, be_i, raddr_i, re_i,
        output dout_o, dout_valid_o
    );
endinterface

// File: rtl/rl_ram_1r1w_fwd.sv
// Generic 1R1W RAM, byte-enable writes, 1 or 2 cycle read
// latency, optional per-byte read-during-write forwarding.
module rl_ram_1r1w_fwd #(
    parameter int ABITS   = 8,
    parameter int DBITS   = 32,
    parameter int REG_OUT = 0,
    parameter int BYPASS  = 1
) (
    input logic clk_i,
    input logic rst_ni,
    rl_ram_1r1w_fwd_if.slave bus
);
    localparam int DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem_q [DEPTH];
    logic [DBITS-1:0] bmask;
    logic [DBITS-1:0] rd_old;
    logic [DBITS-1:0] wr_d;
    logic [DBITS-1:0] rdata1_d;
    logic [DBITS-1:0] rdata1_q;
    logic             rvalid1_q;
    logic             collide;

    // Bit-level write mask; a partial top lane falls out naturally.
    for (genvar b = 0; b < DBITS; b++) begin : g_mask
        assign bmask[b] = bus.be_i[b/8];
    end

    assign rd_old = mem_q[bus.raddr_i];
    assign wr_d = (mem_q[bus.waddr_i] & ~bmask)
                | (bus.din_i & bmask);

    // Stage-1 read data, merging same-cycle write lanes if enabled.
    always_comb begin
        collide = bus.we_i && (bus.raddr_i == bus.waddr_i);
        rdata1_d = rd_old;
        if (BYPASS != 0 && collide) begin
            rdata1_d = (rd_old & ~bmask) | (bus.din_i & bmask);
        end
    end

    // Storage update; contents survive reset but writes are gated by it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && bus.we_i) begin
            mem_q[bus.waddr_i] <= wr_d;
        end
    end

    // Stage-1 capture; holds data when no read is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid1_q <= bus.re_i;
            if (bus.re_i) begin
                rdata1_q <= rdata1_d;
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [DBITS-1:0] dout_q;
        logic             rvalid2_q;

        // Output register stage, loads only behind a valid stage-1 word.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dout_q    <= '0;
                rvalid2_q <= 1'b0;
            end else begin
                rvalid2_q <= rvalid1_q;
                if (rvalid1_q) begin
                    dout_q <= rdata1_q;
                end
            end
        end

        assign bus.dout_o       = dout_q;
        assign bus.dout_valid_o = rvalid2_q;
    end else begin : g_noreg
        assign bus.dout_o       = rdata1_q;
        assign bus.dout_valid_o = rvalid1_q;
    end
endmodule

// File: tb/tb_rl_ram_1r1w_fwd.sv
// Bench: three RAM configurations driven by directed and random
// steps, checked against a schedule-based memory model.
module tb_rl_ram_1r1w_fwd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // 0: lat1 bypass, 1: lat2 read-first, 2: 12-bit lat1 bypass
    int lat [3] = '{1, 2, 1};
    bit byp [3] = '{1'b1, 1'b0, 1'b1};
    int wid [3] = '{32, 32, 12};

    logic [3:0]  wa  [3];
    logic [3:0]  ra  [3];
    logic [31:0] din [3];
    logic [3:0]  be  [3];
    logic        we  [3];
    logic        re  [3];

    logic [31:0] mm     [3][16];
    logic [31:0] slot_d [3][4];
    bit          slot_v [3][4];
    logic [31:0] exp_d  [3];
    bit          exp_v  [3];

    rl_ram_1r1w_fwd_if #(.ABITS(4), .DBITS(32)) ia ();
    rl_ram_1r1w_fwd_if #(.ABITS(4), .DBITS(32)) ib ();
    rl_ram_1r1w_fwd_if #(.ABITS(4), .DBITS(12)) ic ();

    assign ia.waddr_i = wa[0];
    assign ia.raddr_i = ra[0];
    assign ia.din_i   = din[0];
    assign ia.be_i    = be[0];
    assign ia.we_i    = we[0];
    assign ia.re_i    = re[0];
    assign ib.waddr_i = wa[1];
    assign ib.raddr_i = ra[1];
    assign ib.din_i   = din[1];
    assign ib.be_i    = be[1];
    assign ib.we_i    = we[1];
    assign ib.re_i    = re[1];
    assign ic.waddr_i = wa[2];
    assign ic.raddr_i = ra[2];
    assign ic.din_i   = din[2][11:0];
    assign ic.be_i    = be[2][1:0];
    assign ic.we_i    = we[2];
    assign ic.re_i    = re[2];

    rl_ram_1r1w_fwd #(
        .ABITS(4), .DBITS(32), .REG_OUT(0), .BYPASS(1)
    ) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ia));

    rl_ram_1r1w_fwd #(
        .ABITS(4), .DBITS(32), .REG_OUT(1), .BYPASS(0)
    ) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ib));

    rl_ram_1r1w_fwd #(
        .ABITS(4), .DBITS(12), .REG_OUT(0), .BYPASS(1)
    ) dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(ic));

    function automatic logic [31:0] bm(int i, logic [3:0] b);
        logic [31:0] m = '0;
        for (int j = 0; j < wid[i]; j++) m[j] = b[j/8];
        return m;
    endfunction

    function automatic logic [31:0] dout_of(int i);
        case (i)
            0: return ia.dout_o;
            1: return ib.dout_o;
            default: return {20'd0, ic.dout_o};
        endcase
    endfunction

    function automatic logic valid_of(int i);
        case (i)
            0: return ia.dout_valid_o;
            1: return ib.dout_valid_o;
            default: return ic.dout_valid_o;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 4; s++) slot_v[i][s] = 1'b0;
            exp_d[i] = '0;
            exp_v[i] = 1'b0;
        end
    endtask

    // Reads are scheduled to become visible lat-1 edges after issue.
    task automatic model_edge();
        logic [31:0] m, old, d;
        int s;
        cyc++;
        if (!rst_n) return;
        for (int i = 0; i < 3; i++) begin
            m = bm(i, be[i]);
            if (re[i]) begin
                old = mm[i][ra[i]];
                d = old;
                if (byp[i] && we[i] && ra[i] == wa[i])
                    d = (old & ~m) | (din[i] & m);
                s = (cyc + lat[i] - 1) % 4;
                slot_d[i][s] = d;
                slot_v[i][s] = 1'b1;
            end
            if (we[i])
                mm[i][wa[i]] = (mm[i][wa[i]] & ~m) | (din[i] & m);
            s = cyc % 4;
            exp_v[i] = slot_v[i][s];
            if (slot_v[i][s]) exp_d[i] = slot_d[i][s];
            slot_v[i][s] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i), {31'd0, valid_of(i)},
                {31'd0, exp_v[i]});
            chk($sformatf("dout%0d", i), dout_of(i), exp_d[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            we[i] = 1'b0;
            re[i] = 1'b0;
            be[i] = 4'h0;
            wa[i] = 4'h0;
            ra[i] = 4'h0;
            din[i] = '0;
        end
    endtask

    task automatic wr(int i, int a, logic [31:0] d, logic [3:0] b);
        we[i] = 1'b1;
        wa[i] = 4'(a);
        din[i] = d;
        be[i] = b;
    endtask

    task automatic rd(int i, int a);
        re[i] = 1'b1;
        ra[i] = 4'(a);
    endtask

    initial begin
        idle();
        model_reset();
        tick();
        tick();
        chk("rst_valid_b", {31'd0, ib.dout_valid_o}, 32'd0);
        chk("rst_dout_b", ib.dout_o, 32'd0);
        rst_n = 1'b1;

        // fill every location of every instance
        for (int a = 0; a < 16; a++) begin
            for (int i = 0; i < 3; i++) wr(i, a, $urandom, 4'hF);
            tick();
        end
        idle();

        // T1: basic write then read, latency 1
        wr(0, 3, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        rd(0, 3);
        tick();
        idle();
        chk("t1_valid", {31'd0, ia.dout_valid_o}, 32'd1);
        chk("t1_data", ia.dout_o, 32'hDEADBEEF);
        tick();
        chk("t1_drop", {31'd0, ia.dout_valid_o}, 32'd0);

        // T2: byte enables
        wr(0, 5, 32'h11223344, 4'hF);
        tick();
        wr(0, 5, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        rd(0, 5);
        tick();
        idle();
        chk("t2_data", ia.dout_o, 32'h11BB33DD);

        // T3: collision, bypass on A and read-first on B
        wr(0, 7, 32'h0, 4'hF);
        wr(1, 7, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 2; i++) begin
            wr(i, 7, 32'hFF000000, 4'b1000);
            rd(i, 7);
        end
        tick();
        idle();
        chk("t3_byp", ia.dout_o, 32'hFF000000);
        tick();
        chk("t3_rf_valid", {31'd0, ib.dout_valid_o}, 32'd1);
        chk("t3_rf", ib.dout_o, 32'h00000000);
        rd(1, 7);
        tick();
        idle();
        tick();
        chk("t3_rf_next", ib.dout_o, 32'hFF000000);

        // T4: streaming on the registered-output instance
        for (int a = 0; a < 3; a++) begin
            wr(1, a, 32'hA0 + 32'(a), 4'hF);
            tick();
        end
        idle();
        for (int a = 0; a < 3; a++) begin
            rd(1, a);
            tick();
            if (a == 0)
                chk("t4_lat", {31'd0, ib.dout_valid_o}, 32'd0);
            else
                chk($sformatf("t4_d%0d", a - 1), ib.dout_o,
                    32'hA0 + 32'(a - 1));
        end
        idle();
        tick();
        chk("t4_d2", ib.dout_o, 32'hA2);
        chk("t4_v2", {31'd0, ib.dout_valid_o}, 32'd1);
        tick();
        chk("t4_hold", ib.dout_o, 32'hA2);
        chk("t4_end", {31'd0, ib.dout_valid_o}, 32'd0);

        // T5: asynchronous reset with a read in flight
        rd(1, 1);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_v", {31'd0, ib.dout_valid_o}, 32'd0);
        chk("t5_rst_d", ib.dout_o, 32'd0);
        wr(1, 1, 32'h0, 4'hF);
        tick();
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_nopulse", {31'd0, ib.dout_valid_o}, 32'd0);
        rd(1, 1);
        tick();
        idle();
        tick();
        chk("t5_kept", ib.dout_o, 32'hA1);

        // T6: partial top lane
        wr(2, 9, 32'h123, 4'b0011);
        tick();
        wr(2, 9, 32'hABC, 4'b0010);
        tick();
        idle();
        rd(2, 9);
        tick();
        idle();
        chk("t6_data", {20'd0, ic.dout_o}, 32'hA23);

        // random traffic with frequent address collisions
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                we[i] = 1'($urandom_range(0, 1));
                re[i] = 1'($urandom_range(0, 1));
                be[i] = 4'($urandom);
                wa[i] = 4'($urandom);
                ra[i] = ($urandom_range(0, 3) == 0) ? wa[i]
                                                    : 4'($urandom);
                din[i] = $urandom;
            end
            tick();
        end
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rl_ram_1r1w_fwd.md
Name: rl_ram_1r1w_fwd

Overview:
Parametrised, technology-independent 1R1W RAM with byte-granular writes. Adds selectable read latency (1 or 2 cycles), a read-data valid flag, and optional byte-wise read-during-write forwarding. Used as the generic simulation/FPGA model behind the vendor RAM wrappers, and directly in caches and register files that need deterministic collision behaviour.

Parameters:
ABITS, 8, address width; depth = 2**ABITS words
DBITS, 32, data width in bits; any value >= 1; last byte lane holds DBITS%8 bits when DBITS is not a multiple of 8
REG_OUT, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles
BYPASS, 1, 1: same-cycle write to the read address is forwarded per byte; 0: read-first (old data returned)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active low
waddr_i  in  ABITS  write address
din_i  in  DBITS  write data
we_i  in  1  write enable
be_i  in  (DBITS+7)/8  byte enables; bit k covers data bits [8k+7:8k]
raddr_i  in  ABITS  read address
re_i  in  1  read enable
dout_o  out  DBITS  read data
dout_valid_o  out  1  dout_o carries data for a read issued REG_OUT+1 cycles earlier

Behaviour:
- Storage: 2**ABITS x DBITS array. Not reset; unwritten locations read as X. rst_ni never alters contents.
- Write: at posedge clk_i with we_i=1, every lane k with be_i[k]=1 takes din_i lane k at waddr_i. Lanes with be_i[k]=0 are unchanged. we_i=1 with be_i=0 is a no-op.
- Read stage 1: at posedge clk_i with re_i=1, capture rdata1 = mem[raddr_i] with collision handling as below. re_i=0 leaves rdata1 unchanged (hold).
- Collision (re_i & we_i & raddr_i==waddr_i in the same cycle):
  - BYPASS=1: lane k = din_i lane k if be_i[k], else old mem lane k.
  - BYPASS=0: all lanes = old mem content (read-first).
  - Never X for written locations.
- REG_OUT=0: dout_o = rdata1. Latency 1: data for a read at edge N is visible after edge N.
- REG_OUT=1: dout_o register loads rdata1 at every edge where stage-1 valid is set; otherwise holds. Latency 2. A write in the cycle after the read does not affect data already captured in stage 1.
- dout_valid_o: shift pipeline of re_i, REG_OUT+1 stages deep. dout_valid_o=1 exactly REG_OUT+1 cycles after re_i=1, for one cycle per read. Back-to-back reads give continuous valid, one word per cycle, no bubbles.
- dout_o holds its last value while dout_valid_o=0.
- Reset (rst_ni=0, asynchronous):
  - dout_o=0, dout_valid_o=0, all internal valid stages=0, rdata1=0.
  - Reads in flight are discarded.
  - Writes are suppressed while rst_ni=0.
  - After release, the first read behaves normally.
- Address wrap: no wrap logic is needed; the full 2**ABITS range is addressable. Addresses are never truncated or extended internally.
- Partial lane (DBITS%8 != 0): the top be_i bit controls only the remaining high bits.
- No handshake back-pressure: the consumer must accept dout_o when dout_valid_o=1.

Test Plan:
1. ABITS=4, DBITS=32, REG_OUT=0. Write 0xDEADBEEF to addr 3 (be=0xF), then read addr 3 -> dout_o=0xDEADBEEF with dout_valid_o=1 exactly 1 cycle after re_i.
2. Byte enables: addr 5 holds 0x11223344; write 0xAABBCCDD with be=0b0101 -> a later read returns 0x11BB33DD.
3. Collision with BYPASS=1: addr 7 holds 0x00000000; same cycle we=1, be=0b1000, din=0xFF000000, re=1, raddr=7 -> dout_o=0xFF000000. Repeat with BYPASS=0 -> dout_o=0x00000000, and a next read returns 0xFF000000.
4. REG_OUT=1 streaming: reads of addrs 0,1,2 on consecutive cycles (contents 0xA0, 0xA1, 0xA2) -> dout_valid_o high for 3 consecutive cycles starting 2 cycles after the first re_i; data appears in order; dout_o holds 0xA2 afterwards.
5. Reset mid-read, REG_OUT=1: issue a read, assert rst_ni=0 one cycle later -> dout_o=0 and dout_valid_o=0 immediately and no valid pulse afterwards; memory contents preserved (a read after release returns the pre-reset data).
6. DBITS=12, be=0b10, din=0xABC over 0x123 -> read returns 0xA23.
